dm_sba_resp: RTL and testbench



---
 rtl/dm_sba_resp.sv | 168 ++++++++++++++++
 tb/tb_dm_sba_resp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_sba_resp.sv
`default_nettype none
// ============================================================================
//  Module   : dm_sba_resp
//  Purpose  : System-bus-access responder (req/gnt/r_valid protocol) in front
//             of a small word-addressed scratch memory. Grant latency and
//             response latency are set by parameters. A stall input
//             withholds the grant. Accesses outside the region return an
//             error response.
//  Ports    : clk_i, rst_ni      - clock, asynchronous active-low reset
//             stall_i            - withholds gnt while high
//             slave_req_i        - request valid, held until gnt
//             slave_add_i        - byte address
//             slave_we_i         - 1 = write, 0 = read
//             slave_wdata_i      - write data
//             slave_be_i         - byte enables for writes
//             slave_gnt_o        - single-cycle accept strobe
//             slave_r_valid_o    - single-cycle response strobe
//             slave_r_rdata_o    - read data, zero unless a successful read
//             slave_r_err_o      - error flag, qualified by r_valid
//  Revision : 1.0 - initial release
// ============================================================================
module dm_sba_resp #(
   parameter int unsigned BusWidth = 32,
   parameter int unsigned Depth    = 16,
   parameter logic [63:0] BaseAddr = 64'h1000,
   parameter int unsigned GntDelay = 0,
   parameter int unsigned RspDelay = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  stall_i,
   input  logic                  slave_req_i,
   input  logic [BusWidth-1:0]   slave_add_i,
   input  logic                  slave_we_i,
   input  logic [BusWidth-1:0]   slave_wdata_i,
   input  logic [BusWidth/8-1:0] slave_be_i,
   output logic                  slave_gnt_o,
   output logic                  slave_r_valid_o,
   output logic [BusWidth-1:0]   slave_r_rdata_o,
   output logic                  slave_r_err_o
);

   localparam int unsigned BeW  = BusWidth / 8;
   localparam int unsigned OffW = $clog2(BeW);
   localparam int unsigned IdxW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(GntDelay + 2);
   localparam int unsigned RspW = $clog2(RspDelay + 1);

   // One extra bit keeps the upper bound from wrapping when the region
   // sits at the very top of the address space.
   localparam logic [BusWidth:0] RegionLo = {1'b0, BaseAddr[BusWidth-1:0]};
   localparam logic [BusWidth:0] RegionHi = RegionLo + (BusWidth+1)'(Depth * BeW);

   typedef enum logic [1:0] {
      Idle = 2'd0,
      Hold = 2'd1,
      Resp = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [RspW-1:0]     rcnt_q, rcnt_d;
   logic [BusWidth-1:0] mem_q [Depth];
   logic [BusWidth-1:0] rdata_q;
   logic                err_q;

   logic                gnt;
   logic                hit;
   logic                r_valid;
   logic [IdxW-1:0]     idx;

   assign hit = ({1'b0, slave_add_i} >= RegionLo) && ({1'b0, slave_add_i} < RegionHi);
   assign idx = slave_add_i[OffW +: IdxW];

   // --------------------------------------------------------------------
   // Next-state logic. cnt_q counts Hold cycles; the Idle cycle in which
   // req first appeared is the first held cycle, hence the +1 below.
   // --------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rcnt_d  = rcnt_q;
      gnt     = 1'b0;
      unique case (state_q)
         Idle: begin
            if (slave_req_i) begin
               if ((GntDelay == 0) && !stall_i) begin
                  gnt     = 1'b1;
                  state_d = Resp;
                  rcnt_d  = RspW'(1);
               end else begin
                  state_d = Hold;
                  cnt_d   = '0;
               end
            end
         end
         Hold: begin
            if (!slave_req_i) begin
               state_d = Idle;
            end else if ((int'(cnt_q) + 1 >= int'(GntDelay)) && !stall_i) begin
               gnt     = 1'b1;
               state_d = Resp;
               rcnt_d  = RspW'(1);
            end else if (int'(cnt_q) < int'(GntDelay)) begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         Resp: begin
            // Grant is never given here: only one transaction in flight.
            if (rcnt_q == RspW'(RspDelay)) begin
               state_d = Idle;
            end else begin
               rcnt_d = rcnt_q + RspW'(1);
            end
         end
         default: state_d = Idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         cnt_q   <= '0;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // --------------------------------------------------------------------
   // Response capture at the grant edge. Non-read or missed accesses
   // leave rdata_q at zero so the output needs no further qualification.
   // --------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (gnt) begin
         err_q   <= !hit;
         rdata_q <= (hit && !slave_we_i) ? mem_q[idx] : '0;
      end
   end

   // Scratch memory, cleared by reset, byte-granular writes on hit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int w = 0; w < int'(Depth); w++) begin
            mem_q[w] <= '0;
         end
      end else if (gnt && hit && slave_we_i) begin
         for (int b = 0; b < int'(BeW); b++) begin
            if (slave_be_i[b]) begin
               mem_q[idx][8*b +: 8] <= slave_wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign r_valid         = (state_q == Resp) && (rcnt_q == RspW'(RspDelay));
   assign slave_gnt_o     = gnt;
   assign slave_r_valid_o = r_valid;
   assign slave_r_rdata_o = r_valid ? rdata_q : '0;
   assign slave_r_err_o   = r_valid & err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_sba_resp
//  Purpose  : Self-checking bench for dm_sba_resp. Three instances cover
//             the latency configurations: A (GntDelay 0, RspDelay 1),
//             B (GntDelay 2, RspDelay 3), C (GntDelay 3, RspDelay 1).
//             Expected responses go into a scoreboard at the grant and are
//             compared when r_valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_sba_resp;

   logic        clk;
   logic        rst_n;
   logic        req   [3];
   logic        we    [3];
   logic        stall [3];
   logic [31:0] add   [3];
   logic [31:0] wdata [3];
   logic [3:0]  be    [3];
   logic        gnt   [3];
   logic        rv    [3];
   logic        err   [3];
   logic [31:0] rdata [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          id;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dm_sba_resp #(.BusWidth(32), .Depth(16), .BaseAddr(64'h1000), .GntDelay(0), .RspDelay(1)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[0]), .slave_req_i(req[0]),
      .slave_add_i(add[0]), .slave_we_i(we[0]), .slave_wdata_i(wdata[0]), .slave_be_i(be[0]),
      .slave_gnt_o(gnt[0]), .slave_r_valid_o(rv[0]), .slave_r_rdata_o(rdata[0]), .slave_r_err_o(err[0]));

   dm_sba_resp #(.BusWidth(32), .Depth(16), .BaseAddr(64'h1000), .GntDelay(2), .RspDelay(3)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[1]), .slave_req_i(req[1]),
      .slave_add_i(add[1]), .slave_we_i(we[1]), .slave_wdata_i(wdata[1]), .slave_be_i(be[1]),
      .slave_gnt_o(gnt[1]), .slave_r_valid_o(rv[1]), .slave_r_rdata_o(rdata[1]), .slave_r_err_o(err[1]));

   dm_sba_resp #(.BusWidth(32), .Depth(16), .BaseAddr(64'h1000), .GntDelay(3), .RspDelay(1)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[2]), .slave_req_i(req[2]),
      .slave_add_i(add[2]), .slave_we_i(we[2]), .slave_wdata_i(wdata[2]), .slave_be_i(be[2]),
      .slave_gnt_o(gnt[2]), .slave_r_valid_o(rv[2]), .slave_r_rdata_o(rdata[2]), .slave_r_err_o(err[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every r_valid must match the oldest scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         if (rv[i] === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_rvalid", 64'(rv[i]), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_instance", 64'(i), 64'(e.id));
               chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
               chk("rsp_err", 64'(err[i]), 64'(e.err));
               chk("rsp_rdata", 64'(rdata[i]), 64'(e.rdata));
            end
         end
      end
   end

   // One complete transaction: drive, wait for gnt (stall held for the
   // first nstall cycles), push the expectation, then wait for the response.
   task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int nstall, input int exp_lat, input int rsp,
                      input logic e_err, input logic [31:0] e_rd);
      int k;
      @(posedge clk); #1;
      req[i] = 1'b1; we[i] = w; add[i] = a; wdata[i] = d; be[i] = b;
      for (k = 0; k < 40; k++) begin
         stall[i] = (k < nstall);
         @(negedge clk);
         if (gnt[i] === 1'b1) begin
            sb.push_back('{id: i, err: e_err, rdata: e_rd, cyc: cyc + rsp});
            break;
         end
         @(posedge clk); #1;
      end
      chk("gnt_latency", 64'(k), 64'(exp_lat));
      @(posedge clk); #1;
      req[i] = 1'b0; stall[i] = 1'b0;
      for (int t = 0; t < rsp + 4 && sb.size() != 0; t++) @(posedge clk);
      chk("rsp_outstanding", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req[i] = 0; we[i] = 0; stall[i] = 0; add[i] = 0; wdata[i] = 0; be[i] = 0;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("reset_gnt", 64'(gnt[i]), 64'd0);
         chk("reset_rvalid", 64'(rv[i]), 64'd0);
         chk("reset_err", 64'(err[i]), 64'd0);
         chk("reset_rdata", 64'(rdata[i]), 64'd0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // ---- Instance A: basic function, partial writes, errors, boundary
      txn(0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 32'h0);
      txn(0, 0, 32'h1004, 32'h0,        4'h0, 0, 0, 1, 0, 32'hDEADBEEF);
      txn(0, 1, 32'h1008, 32'h11223344, 4'h5, 0, 0, 1, 0, 32'h0);
      txn(0, 0, 32'h1008, 32'h0,        4'h0, 0, 0, 1, 0, 32'h00220044);
      txn(0, 1, 32'h1008, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 0, 32'h0);
      txn(0, 0, 32'h1008, 32'h0,        4'h0, 0, 0, 1, 0, 32'h00220044);
      txn(0, 0, 32'h0FFC, 32'h0,        4'h0, 0, 0, 1, 1, 32'h0);
      txn(0, 1, 32'h1040, 32'h55AA55AA, 4'hF, 0, 0, 1, 1, 32'h0);
      txn(0, 0, 32'h1000, 32'h0,        4'h0, 0, 0, 1, 0, 32'h0);
      txn(0, 1, 32'h103C, 32'hA5A5C3C3, 4'hF, 0, 0, 1, 0, 32'h0);
      txn(0, 0, 32'h103F, 32'h0,        4'h0, 0, 0, 1, 0, 32'hA5A5C3C3);
      txn(0, 0, 32'h1004, 32'h0,        4'h0, 2, 2, 1, 0, 32'hDEADBEEF);

      // ---- Instance A: req held high -> no grant while a response is pending
      @(posedge clk); #1;
      req[0] = 1; we[0] = 0; add[0] = 32'h1004;
      @(negedge clk);
      chk("held_gnt_first", 64'(gnt[0]), 64'd1);
      sb.push_back('{id: 0, err: 1'b0, rdata: 32'hDEADBEEF, cyc: cyc + 1});
      @(negedge clk);
      chk("held_gnt_in_resp", 64'(gnt[0]), 64'd0);
      @(negedge clk);
      chk("held_gnt_second", 64'(gnt[0]), 64'd1);
      sb.push_back('{id: 0, err: 1'b0, rdata: 32'hDEADBEEF, cyc: cyc + 1});
      @(posedge clk); #1 req[0] = 0;
      repeat (3) @(posedge clk);
      chk("held_outstanding", 64'(sb.size()), 64'd0);
      sb.delete();

      // ---- Instance B: grant/response latency and backpressure
      txn(1, 0, 32'h1000, 32'h0,        4'h0, 0, 2, 3, 0, 32'h0);
      txn(1, 1, 32'h1010, 32'hCAFEF00D, 4'hF, 5, 5, 3, 0, 32'h0);
      txn(1, 0, 32'h1010, 32'h0,        4'h0, 0, 2, 3, 0, 32'hCAFEF00D);

      // ---- Instance C: abandoned write leaves no trace
      @(posedge clk); #1;
      req[2] = 1; we[2] = 1; add[2] = 32'h100C; wdata[2] = 32'h12345678; be[2] = 4'hF;
      @(negedge clk); chk("abandon_gnt_c0", 64'(gnt[2]), 64'd0);
      @(posedge clk); #1;
      @(negedge clk); chk("abandon_gnt_c1", 64'(gnt[2]), 64'd0);
      @(posedge clk); #1 req[2] = 0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk); chk("abandon_gnt_idle", 64'(gnt[2]), 64'd0);
      end
      txn(2, 0, 32'h100C, 32'h0,        4'h0, 0, 3, 1, 0, 32'h0);
      txn(2, 1, 32'h100C, 32'h87654321, 4'hF, 0, 3, 1, 0, 32'h0);
      txn(2, 0, 32'h100C, 32'h0,        4'h0, 0, 3, 1, 0, 32'h87654321);

      // ---- Instance B: reset one cycle after a grant drops the response
      @(posedge clk); #1;
      req[1] = 1; we[1] = 0; add[1] = 32'h1010;
      for (k = 0; k < 10; k++) begin
         @(negedge clk);
         if (gnt[1] === 1'b1) break;
         @(posedge clk); #1;
      end
      chk("reset_txn_gnt_latency", 64'(k), 64'd2);
      @(posedge clk); #1;
      req[1] = 0; rst_n = 1'b0;
      #1;
      chk("midreset_rvalid", 64'(rv[1]), 64'd0);
      chk("midreset_rdata", 64'(rdata[1]), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      txn(1, 0, 32'h1010, 32'h0, 4'h0, 0, 2, 3, 0, 32'h0);
      txn(0, 0, 32'h1004, 32'h0, 4'h0, 0, 0, 1, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
